rr_arbiter4: RTL and testbench

RR_ARBITER4 -- requirements
Module: rr_arbiter4

---
 rtl/rr_arbiter4.sv | 151 +++++++++++++++
 tb/tb_rr_arbiter4.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with registered grant, driving a downstream 4:1 mux select.
// Optional forced-release timeout is compiled in when RR_ARB4_TIMEOUT_EN is defined.
module rr_arbiter4 #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       ack,
    output logic       gnt_vld,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       timeout
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] gnt_q, gnt_d;
    logic       gnt_vld_q, gnt_vld_d;
    logic       release_grant;
    logic       expire;
    logic [1:0] arb_ptr;
    logic       arb_found;
    logic [1:0] arb_idx;

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout_cyc
        $error("rr_arbiter4: TIMEOUT_CYC must be in 1..255");
    end

    // Returns {found, index} of the first set request searching from ptr upward, mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic       found;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = p + 2'(i);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

`ifdef RR_ARB4_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;
    logic       timeout_q, timeout_d;

    assign cnt_inc = cnt_q + 8'd1;
    assign expire  = (state_q == StGrant) && !ack && (cnt_inc == 8'(TIMEOUT_CYC));
    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign release_grant = (state_q == StGrant) && (ack || expire);

    // On release the search starts just past the winner being released.
    assign arb_ptr              = release_grant ? (sel_q + 2'd1) : ptr_q;
    assign {arb_found, arb_idx} = rr_pick(req, arb_ptr);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        gnt_vld_d = gnt_vld_q;
`ifdef RR_ARB4_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                gnt_vld_d = 1'b0;
                gnt_d     = 4'b0000;
                if (arb_found) begin
                    state_d   = StGrant;
                    sel_d     = arb_idx;
                    gnt_d     = 4'b0001 << arb_idx;
                    gnt_vld_d = 1'b1;
`ifdef RR_ARB4_TIMEOUT_EN
                    cnt_d     = 8'd0;
`endif
                end
            end
            StGrant: begin
                if (release_grant) begin
                    ptr_d = arb_ptr;
`ifdef RR_ARB4_TIMEOUT_EN
                    timeout_d = expire;
                    cnt_d     = 8'd0;
`endif
                    if (arb_found) begin
                        sel_d     = arb_idx;
                        gnt_d     = 4'b0001 << arb_idx;
                        gnt_vld_d = 1'b1;
                    end else begin
                        state_d   = StIdle;
                        gnt_d     = 4'b0000;
                        gnt_vld_d = 1'b0;
                    end
                end else begin
`ifdef RR_ARB4_TIMEOUT_EN
                    cnt_d = cnt_inc;
`endif
                end
            end
            default: begin
                state_d   = StIdle;
                gnt_d     = 4'b0000;
                gnt_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= 2'd0;
            sel_q     <= 2'd0;
            gnt_q     <= 4'b0000;
            gnt_vld_q <= 1'b0;
`ifdef RR_ARB4_TIMEOUT_EN
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            gnt_vld_q <= gnt_vld_d;
`ifdef RR_ARB4_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign gnt_vld = gnt_vld_q;
    assign sel     = sel_q;
    assign gnt     = gnt_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed self-checking bench for rr_arbiter4; timeout section follows RR_ARB4_TIMEOUT_EN.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic       gnt_vld;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    rr_arbiter4 #(
        .TIMEOUT_CYC(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .ack    (ack),
        .gnt_vld(gnt_vld),
        .sel    (sel),
        .gnt    (gnt),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input logic [1:0] s);
        logic [3:0] oh;
        oh = 4'b0001 << s;
        check_eq({tag, ".vld"}, 32'(gnt_vld), 32'd1);
        check_eq({tag, ".sel"}, 32'(sel), 32'(s));
        check_eq({tag, ".gnt"}, 32'(gnt), 32'(oh));
    endtask

    task automatic expect_idle(input string tag);
        check_eq({tag, ".vld"}, 32'(gnt_vld), 32'd0);
        check_eq({tag, ".gnt"}, 32'(gnt), 32'd0);
    endtask

    logic [1:0] rr_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        ack = 1'b0;
        cycle();
        cycle();
        expect_idle("reset");
        check_eq("reset.sel", 32'(sel), 32'd0);
        check_eq("reset.timeout", 32'(timeout), 32'd0);

        // Single requester 2, then release with nothing pending.
        rst = 1'b0;
        req = 4'b0100;
        cycle();
        expect_grant("first", 2'd2);
        req = 4'b0000;
        ack = 1'b1;
        cycle();
        expect_idle("release_idle");
        check_eq("release_idle.sel", 32'(sel), 32'd2);

        // ack while idle must not move ptr (still 3).
        cycle();
        expect_idle("ack_in_idle");
        ack = 1'b0;
        req = 4'b1111;
        cycle();
        expect_grant("ptr3", 2'd3);

        // All requesting, ack every grant: strict rotation from ptr 0.
        ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            expect_grant($sformatf("rotate%0d", i), rr_seq[i]);
        end

        // Move grant to 1, then hold it against changing req.
        req = 4'b0010;
        cycle();
        expect_grant("to_sel1", 2'd1);
        ack = 1'b0;
        req = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            cycle();
            expect_grant($sformatf("hold%0d", i), 2'd1);
        end
        ack = 1'b1;
        cycle();
        expect_grant("after_hold", 2'd3);

        // Get sel 2, then release it with req 0011: search 3,0 wraps to 0.
        req = 4'b0100;
        cycle();
        expect_grant("to_sel2", 2'd2);
        req = 4'b0011;
        cycle();
        expect_grant("wrap", 2'd0);

        // Sole persistent requester re-granted each ack.
        req = 4'b0001;
        cycle();
        expect_grant("sole0", 2'd0);
        cycle();
        expect_grant("sole1", 2'd0);

        // Reset while granting sel 2.
        req = 4'b0100;
        cycle();
        expect_grant("pre_rst", 2'd2);
        ack = 1'b0;
        rst = 1'b1;
        cycle();
        expect_idle("rst_in_grant");
        check_eq("rst_in_grant.sel", 32'(sel), 32'd0);
        check_eq("rst_in_grant.timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        req = 4'b0110;
        cycle();
        expect_grant("post_rst", 2'd1);

        // Timeout behaviour from a fresh reset with sole requester 0 and no ack.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req = 4'b0001;
        cycle();
        expect_grant("to_grant", 2'd0);
`ifdef RR_ARB4_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq($sformatf("to_wait%0d", i), 32'(timeout), 32'd0);
            expect_grant($sformatf("to_wait%0d", i), 2'd0);
        end
        cycle();
        check_eq("to_pulse", 32'(timeout), 32'd1);
        expect_grant("to_regrant", 2'd0);
        cycle();
        check_eq("to_pulse_end", 32'(timeout), 32'd0);
        expect_grant("to_after", 2'd0);
`else
        for (int i = 0; i < 50; i++) begin
            cycle();
            check_eq($sformatf("no_to%0d", i), 32'(timeout), 32'd0);
        end
        expect_grant("no_to_held", 2'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
